// File: rtl/resp_sig_analyzer.sv
// Output response analyzer: compacts N_PAT valid response bits into a Galois
// SISR and compares the final signature against GOLDEN.
module resp_sig_analyzer #(
  parameter int                SIG_W  = 16,
  parameter logic [SIG_W-1:0]  POLY   = 16'h8005,
  parameter logic [SIG_W-1:0]  SEED   = 16'h0000,
  parameter int                N_PAT  = 64,
  parameter logic [SIG_W-1:0]  GOLDEN = 16'h0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   z_in,
  input  logic                   z_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [SIG_W-1:0]       signature,
  output logic [$clog2(N_PAT):0] pat_cnt
);

  localparam int CNT_W = $clog2(N_PAT) + 1;

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic             busy_next;
  logic             done_next;
  logic             fb;
  logic             last_beat;
  logic [SIG_W-1:0] sig_step;

  assign fb        = signature[SIG_W-1] ^ z_in;
  assign sig_step  = {signature[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  assign last_beat = z_valid && (pat_cnt == CNT_W'(N_PAT - 1));

  // State, datapath and registered flags; start always wins over z_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      signature <= SEED;
      pat_cnt   <= '0;
      pass      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= busy_next;
      done  <= done_next;
      if (start) begin
        signature <= SEED;
        pat_cnt   <= '0;
        pass      <= 1'b0;
      end else begin
        case (state)
          RUN: begin
            if (z_valid) begin
              signature <= sig_step;
              pat_cnt   <= pat_cnt + CNT_W'(1);
            end
          end
          CHECK:   pass <= (signature == GOLDEN);
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = RUN;
      RUN: begin
        if (start)          state_next = RUN;
        else if (last_beat) state_next = CHECK;
      end
      CHECK: state_next = start ? RUN : DONE;
      DONE:  if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Flags are decoded from the next state so they register alongside it
  always_comb begin
    busy_next = (state_next == RUN) || (state_next == CHECK);
    done_next = (state_next == DONE);
  end

endmodule

// File: tb/tb_resp_sig_analyzer.sv
// Bench for resp_sig_analyzer: directed and randomized runs checked against a
// polynomial-remainder model of the signature.
module tb_resp_sig_analyzer;

  localparam int          SIG_W  = 16;
  localparam int          N_PAT  = 64;
  localparam int          CNT_W  = $clog2(N_PAT) + 1;
  localparam logic [15:0] POLY   = 16'h8005;
  localparam logic [15:0] SEED   = 16'h0000;
  localparam logic [15:0] GOLDEN = 16'h0000;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             z_in;
  logic             z_valid;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SIG_W-1:0] signature;
  logic [CNT_W-1:0] pat_cnt;

  int total = 0;
  int bad   = 0;
  bit stim[$];

  resp_sig_analyzer #(
    .SIG_W(SIG_W), .POLY(POLY), .SEED(SEED), .N_PAT(N_PAT), .GOLDEN(GOLDEN)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .z_in(z_in), .z_valid(z_valid),
    .busy(busy), .done(done), .pass(pass), .signature(signature), .pat_cnt(pat_cnt)
  );

  always #5 clk = ~clk;

  // Signature = (SEED*x^n + sum z_k*x^(SIG_W+n-1-k)) mod (x^SIG_W + POLY)
  function automatic logic [SIG_W-1:0] model_sig();
    logic [127:0] m;
    logic [127:0] p;
    int n;
    n = stim.size();
    m = 128'(SEED) << n;
    for (int k = 0; k < n; k++)
      if (stim[k]) m[SIG_W + n - 1 - k] = ~m[SIG_W + n - 1 - k];
    p = 128'({1'b1, POLY});
    for (int i = 127; i >= SIG_W; i--)
      if (m[i]) m = m ^ (p << (i - SIG_W));
    return m[SIG_W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic v, input logic z);
    start   = s;
    z_valid = v;
    z_in    = z;
    tick();
    start   = 1'b0;
    z_valid = 1'b0;
  endtask

  // Drives the beats queued in stim with random idle gaps, checking the count as it goes
  task automatic drive_run(input int max_gap);
    for (int k = 0; k < stim.size(); k++) begin
      int gaps;
      gaps = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gaps; g++) applyStimulus(1'b0, 1'b0, 1'($urandom));
      applyStimulus(1'b0, 1'b1, stim[k]);
      if (k < N_PAT - 1) begin
        total++;
        if (pat_cnt !== CNT_W'(k + 1)) begin
          bad++;
          $display("[TB] FAIL run_pat_cnt beat %0d: got %0d expected %0d", k + 1, pat_cnt, k + 1);
        end
        total++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          bad++;
          $display("[TB] FAIL run_flags beat %0d: got busy=%b done=%b expected busy=1 done=0", k + 1, busy, done);
        end
      end
    end
  endtask

  task automatic start_run(input string tag);
    applyStimulus(1'b1, 1'b0, 1'b0);
    total++;
    if (busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0 || pat_cnt !== '0 || signature !== SEED) begin
      bad++;
      $display("[TB] FAIL %s_start: got busy=%b done=%b pass=%b cnt=%0d sig=%h expected 1 0 0 0 %h",
               tag, busy, done, pass, pat_cnt, signature, SEED);
    end
  endtask

  // Called right after the edge that accepted the final beat
  task automatic check_result(input string tag);
    logic [SIG_W-1:0] e;
    e = model_sig();
    total++;
    if (signature !== e || pat_cnt !== CNT_W'(N_PAT)) begin
      bad++;
      $display("[TB] FAIL %s_check_sig: got sig=%h cnt=%0d expected sig=%h cnt=%0d", tag, signature, pat_cnt, e, N_PAT);
    end
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s_check_state: got busy=%b done=%b expected busy=1 done=0", tag, busy, done);
    end
    applyStimulus(1'b0, 1'b1, 1'b1);
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || pass !== (e == GOLDEN) || signature !== e) begin
      bad++;
      $display("[TB] FAIL %s_done: got done=%b busy=%b pass=%b sig=%h expected 1 0 %b %h",
               tag, done, busy, pass, signature, (e == GOLDEN), e);
    end
    applyStimulus(1'b0, 1'b1, 1'($urandom));
    total++;
    if (done !== 1'b1 || signature !== e || pat_cnt !== CNT_W'(N_PAT) || pass !== (e == GOLDEN)) begin
      bad++;
      $display("[TB] FAIL %s_hold: got done=%b sig=%h cnt=%0d pass=%b expected 1 %h %0d %b",
               tag, done, signature, pat_cnt, pass, e, N_PAT, (e == GOLDEN));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || pat_cnt !== '0 || signature !== SEED) begin
      bad++;
      $display("[TB] FAIL reset: got busy=%b done=%b pass=%b cnt=%0d sig=%h expected 0 0 0 0 %h",
               busy, done, pass, pat_cnt, signature, SEED);
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b1);
    total++;
    if (busy !== 1'b0 || pat_cnt !== '0 || signature !== SEED) begin
      bad++;
      $display("[TB] FAIL idle_ignore: got busy=%b cnt=%0d sig=%h expected 0 0 %h", busy, pat_cnt, signature, SEED);
    end
  endtask

  task automatic test_directed(input string tag, input int one_at, input int max_gap);
    stim.delete();
    for (int k = 0; k < N_PAT; k++) stim.push_back(k == one_at);
    start_run(tag);
    drive_run(max_gap);
    check_result(tag);
  endtask

  task automatic test_restart();
    stim.delete();
    for (int k = 0; k < 20; k++) stim.push_back(1'b1);
    start_run("restart_first");
    drive_run(0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    total++;
    if (pat_cnt !== '0 || signature !== SEED || busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL restart_cycle: got cnt=%0d sig=%h busy=%b done=%b expected 0 %h 1 0",
               pat_cnt, signature, busy, done, SEED);
    end
    stim.delete();
    for (int k = 0; k < N_PAT; k++) stim.push_back(1'b0);
    drive_run(0);
    check_result("restart");
  endtask

  task automatic test_mid_run_reset();
    stim.delete();
    for (int k = 0; k < 30; k++) stim.push_back(1'($urandom));
    start_run("midreset");
    drive_run(1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1);
    rst = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || pat_cnt !== '0 || signature !== SEED) begin
      bad++;
      $display("[TB] FAIL midreset: got busy=%b done=%b pass=%b cnt=%0d sig=%h expected 0 0 0 0 %h",
               busy, done, pass, pat_cnt, signature, SEED);
    end
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'($urandom));
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || pat_cnt !== '0 || signature !== SEED) begin
      bad++;
      $display("[TB] FAIL midreset_idle: got busy=%b done=%b cnt=%0d sig=%h expected 0 0 0 %h",
               busy, done, pat_cnt, signature, SEED);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      stim.delete();
      for (int k = 0; k < N_PAT; k++) stim.push_back(1'($urandom));
      start_run("random");
      drive_run(2);
      check_result("random");
    end
  endtask

  initial begin
    rst     = 1'b0;
    start   = 1'b0;
    z_in    = 1'b0;
    z_valid = 1'b0;
    test_reset();
    test_directed("all_zero", -1, 0);
    test_directed("last_one", N_PAT - 1, 0);
    test_directed("msb_fb", N_PAT - 2, 0);
    test_directed("gaps", -1, 3);
    test_restart();
    test_mid_run_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
